// File: rtl/wb_trace_serializer.sv
// Serialises up to two writeback records per cycle into the single debug
// writeback port through a program-ordered FIFO. Define WB_TRACE_PERF_EN to add stall/occupancy counters.
module wb_trace_serializer #(
    parameter int DEPTH   = 8,
    parameter bit DROP_R0 = 1'b1
) (
    input  logic                      sys_clk,
    input  logic                      resetn,
    input  logic                      wb0_en,
    input  logic [4:0]                wb0_rd,
    input  logic [31:0]               wb0_wdata,
    input  logic [31:0]               wb0_pc,
    input  logic                      wb1_en,
    input  logic [4:0]                wb1_rd,
    input  logic [31:0]               wb1_wdata,
    input  logic [31:0]               wb1_pc,
    output logic                      stall_req,
    output logic [31:0]               debug_wb_pc,
    output logic [3:0]                debug_wb_rf_wen,
    output logic [4:0]                debug_wb_rf_wnum,
    output logic [31:0]               debug_wb_rf_wdata,
    output logic                      overflow
`ifdef WB_TRACE_PERF_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [$clog2(DEPTH):0]    max_occupancy
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW:0] ONE     = (CW+1)'(1);
    localparam logic [CW:0] TWO     = (CW+1)'(2);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [31:0]     r_out_pc;
    logic [3:0]      r_out_wen;
    logic [4:0]      r_out_wnum;
    logic [31:0]     r_out_wdata;

    logic            w_acc0;
    logic            w_acc1;
    logic            w_pop;
    logic [CW:0]     w_space;
    logic            w_keep0;
    logic            w_keep1;
    logic            w_drop;
    logic [1:0]      w_pushes;
    logic [AW-1:0]   w_wr_ptr1;
    logic [CW-1:0]   w_count_next;
    entry_t          w_rec0;
    entry_t          w_rec1;

    assign w_acc0 = wb0_en && !(DROP_R0 && (wb0_rd == 5'd0));
    assign w_acc1 = wb1_en && !(DROP_R0 && (wb1_rd == 5'd0));
    assign w_rec0 = '{pc: wb0_pc, rd: wb0_rd, wdata: wb0_wdata};
    assign w_rec1 = '{pc: wb1_pc, rd: wb1_rd, wdata: wb1_wdata};

    // Pop decision uses occupancy before this edge's pushes, so there is no bypass path.
    assign w_pop   = (r_count != '0);
    assign w_space = DEPTH_W - {1'b0, r_count} + {{CW{1'b0}}, w_pop};

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_keep0 = 1'b0;
        w_keep1 = 1'b0;
        if (w_acc0 && w_acc1) begin
            w_keep0 = (w_space >= ONE);
            w_keep1 = (w_space >= TWO);
        end else if (w_acc0) begin
            w_keep0 = (w_space >= ONE);
        end else if (w_acc1) begin
            w_keep1 = (w_space >= ONE);
        end
    end

    assign w_drop       = (w_acc0 && !w_keep0) || (w_acc1 && !w_keep1);
    assign w_pushes     = {1'b0, w_keep0} + {1'b0, w_keep1};
    // Slot 1 lands behind slot 0 only when slot 0 was actually written this cycle.
    assign w_wr_ptr1    = r_wr_ptr + AW'(w_keep0);
    assign w_count_next = r_count + CW'(w_pushes) - CW'(w_pop);

    // NOTE: storage is not reset; pointers and count define validity, so stale entries are never read.
    always_ff @(posedge sys_clk) begin
        if (w_keep0) r_mem[r_wr_ptr]  <= w_rec0;
        if (w_keep1) r_mem[w_wr_ptr1] <= w_rec1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_out_pc    <= '0;
            r_out_wen   <= 4'h0;
            r_out_wnum  <= '0;
            r_out_wdata <= '0;
        end else begin
            r_count  <= w_count_next;
            r_wr_ptr <= r_wr_ptr + AW'(w_pushes);
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                r_out_wen   <= 4'hf;
                r_out_pc    <= r_mem[r_rd_ptr].pc;
                r_out_wnum  <= r_mem[r_rd_ptr].rd;
                r_out_wdata <= r_mem[r_rd_ptr].wdata;
            end else begin
                r_out_wen   <= 4'h0;
                r_out_wnum  <= '0;
                r_out_wdata <= '0;
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign stall_req         = (DEPTH_W - {1'b0, r_count}) < TWO;
    assign overflow          = r_overflow;
    assign debug_wb_pc       = r_out_pc;
    assign debug_wb_rf_wen   = r_out_wen;
    assign debug_wb_rf_wnum  = r_out_wnum;
    assign debug_wb_rf_wdata = r_out_wdata;

`ifdef WB_TRACE_PERF_EN
    logic [31:0]   r_stall_cycles;
    logic [CW-1:0] r_max_occupancy;

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            r_stall_cycles  <= '0;
            r_max_occupancy <= '0;
        end else begin
            if (stall_req && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (r_count > r_max_occupancy) r_max_occupancy <= r_count;
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign max_occupancy = r_max_occupancy;
`endif

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Self-checking bench: two instances (DROP_R0=1 and DROP_R0=0) share stimulus and
// are compared every cycle against a queue-based reference model.
module tb_wb_trace_serializer;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } rec_t;

    logic        sys_clk = 1'b0;
    logic        resetn;
    logic        wb0_en, wb1_en;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_wdata, wb1_wdata, wb0_pc, wb1_pc;

    logic        d0_stall, d1_stall, d0_ovf, d1_ovf;
    logic [31:0] d0_pc, d1_pc, d0_wdata, d1_wdata;
    logic [3:0]  d0_wen, d1_wen;
    logic [4:0]  d0_wnum, d1_wnum;

    int n_pass  = 0;
    int n_total = 0;

    always #5 sys_clk = ~sys_clk;

    wb_trace_serializer #(.DEPTH(DEPTH), .DROP_R0(1'b1)) u_dut_drop (
        .sys_clk(sys_clk), .resetn(resetn),
        .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_wdata(wb0_wdata), .wb0_pc(wb0_pc),
        .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_wdata(wb1_wdata), .wb1_pc(wb1_pc),
        .stall_req(d0_stall), .debug_wb_pc(d0_pc), .debug_wb_rf_wen(d0_wen),
        .debug_wb_rf_wnum(d0_wnum), .debug_wb_rf_wdata(d0_wdata), .overflow(d0_ovf)
    );

    wb_trace_serializer #(.DEPTH(DEPTH), .DROP_R0(1'b0)) u_dut_keep (
        .sys_clk(sys_clk), .resetn(resetn),
        .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_wdata(wb0_wdata), .wb0_pc(wb0_pc),
        .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_wdata(wb1_wdata), .wb1_pc(wb1_pc),
        .stall_req(d1_stall), .debug_wb_pc(d1_pc), .debug_wb_rf_wen(d1_wen),
        .debug_wb_rf_wnum(d1_wnum), .debug_wb_rf_wdata(d1_wdata), .overflow(d1_ovf)
    );

    // Reference model: model 0 discards rd==0, model 1 keeps it.
    rec_t       mq0[$];
    rec_t       mq1[$];
    rec_t       m_out  [2];
    logic [3:0] m_wen  [2];
    logic       m_ovf  [2];

    function automatic int q_size(input int m);
        return (m == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic bit m_stall(input int m);
        return (DEPTH - q_size(m)) < 2;
    endfunction

    task automatic offer(input int m, input logic en, input rec_t r);
        if (en && !(m == 0 && r.rd == 5'd0)) begin
            if (q_size(m) < DEPTH) begin
                if (m == 0) mq0.push_back(r);
                else        mq1.push_back(r);
            end else begin
                m_ovf[m] = 1'b1;
            end
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            if (!resetn) begin
                if (m == 0) mq0.delete();
                else        mq1.delete();
                m_out[m] = '0;
                m_wen[m] = 4'h0;
                m_ovf[m] = 1'b0;
            end else begin
                if (q_size(m) != 0) begin
                    m_out[m] = (m == 0) ? mq0.pop_front() : mq1.pop_front();
                    m_wen[m] = 4'hf;
                end else begin
                    m_wen[m]       = 4'h0;
                    m_out[m].rd    = '0;
                    m_out[m].wdata = '0;
                end
                offer(m, wb0_en, '{pc: wb0_pc, rd: wb0_rd, wdata: wb0_wdata});
                offer(m, wb1_en, '{pc: wb1_pc, rd: wb1_rd, wdata: wb1_wdata});
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic compare_all();
        check("d0_wen",   64'(d0_wen),   64'(m_wen[0]));
        check("d0_wnum",  64'(d0_wnum),  64'(m_out[0].rd));
        check("d0_wdata", 64'(d0_wdata), 64'(m_out[0].wdata));
        check("d0_pc",    64'(d0_pc),    64'(m_out[0].pc));
        check("d0_ovf",   64'(d0_ovf),   64'(m_ovf[0]));
        check("d0_stall", 64'(d0_stall), 64'(m_stall(0)));
        check("d1_wen",   64'(d1_wen),   64'(m_wen[1]));
        check("d1_wnum",  64'(d1_wnum),  64'(m_out[1].rd));
        check("d1_wdata", 64'(d1_wdata), 64'(m_out[1].wdata));
        check("d1_pc",    64'(d1_pc),    64'(m_out[1].pc));
        check("d1_ovf",   64'(d1_ovf),   64'(m_ovf[1]));
        check("d1_stall", 64'(d1_stall), 64'(m_stall(1)));
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
        compare_all();
    endtask

    task automatic set_wb(input logic e0, input logic [4:0] r0, input logic [31:0] dt0, input logic [31:0] p0,
                          input logic e1, input logic [4:0] r1, input logic [31:0] dt1, input logic [31:0] p1);
        wb0_en = e0; wb0_rd = r0; wb0_wdata = dt0; wb0_pc = p0;
        wb1_en = e1; wb1_rd = r1; wb1_wdata = dt1; wb1_pc = p1;
    endtask

    task automatic idle();
        set_wb(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && (mq0.size() != 0 || mq1.size() != 0); i++) step();
        check("drain_empty", 64'(mq0.size() + mq1.size()), 64'd0);
        step();
    endtask

    task automatic random_phase(input int cycles, input bit honour);
        for (int i = 0; i < cycles; i++) begin
            set_wb(($urandom % 4) != 0, 5'($urandom % 8), $urandom, $urandom,
                   ($urandom % 4) != 0, 5'($urandom % 8), $urandom, $urandom);
            if (honour && (m_stall(0) || m_stall(1))) begin
                wb0_en = 1'b0;
                wb1_en = 1'b0;
            end
            step();
        end
        idle();
    endtask

    logic [31:0] seq [6];
    logic        saw_stall;

    initial begin
        resetn = 1'b0;
        idle();
        step();
        step();
        check("reset_wen", 64'(d0_wen), 64'd0);
        check("reset_pc",  64'(d0_pc),  64'd0);
        resetn = 1'b1;
        step();

        // Single record, one-edge latency, pc holds afterwards.
        set_wb(1'b1, 5'd5, 32'h1234, 32'hbfc00bd4, 1'b0, 5'd0, 32'd0, 32'd0);
        step();
        idle();
        step();
        check("single_wen",   64'(d0_wen),   64'hf);
        check("single_wnum",  64'(d0_wnum),  64'd5);
        check("single_wdata", 64'(d0_wdata), 64'h1234);
        check("single_pc",    64'(d0_pc),    64'hbfc00bd4);
        step();
        check("single_gap_wen", 64'(d0_wen), 64'd0);
        check("single_pc_hold", 64'(d0_pc),  64'hbfc00bd4);

        // Dual issue ordering over three cycles.
        seq = '{32'hA000_0000, 32'hA000_0004, 32'hB000_0000, 32'hB000_0004, 32'hC000_0000, 32'hC000_0004};
        for (int c = 0; c < 3; c++) begin
            set_wb(1'b1, 5'(2 * c + 1), 32'(c), seq[2 * c], 1'b1, 5'(2 * c + 2), 32'(c + 16), seq[2 * c + 1]);
            step();
            if (c >= 1) check("order_pc", 64'(d0_pc), 64'(seq[c - 1]));
        end
        idle();
        for (int k = 2; k < 6; k++) begin
            step();
            check("order_wen", 64'(d0_wen), 64'hf);
            check("order_pc",  64'(d0_pc),  64'(seq[k]));
        end
        step();
        check("order_end_wen", 64'(d0_wen), 64'd0);

        // R0 filter: drop instance shows only rd=3, keep instance shows rd=0 first.
        set_wb(1'b1, 5'd0, 32'hAAAA, 32'h100, 1'b1, 5'd3, 32'hBBBB, 32'h104);
        step();
        idle();
        step();
        check("r0_drop_wnum", 64'(d0_wnum), 64'd3);
        check("r0_drop_pc",   64'(d0_pc),   64'h104);
        check("r0_keep_wnum", 64'(d1_wnum), 64'd0);
        check("r0_keep_pc",   64'(d1_pc),   64'h100);
        step();
        check("r0_drop_done", 64'(d0_wen),  64'd0);
        check("r0_keep_wen",  64'(d1_wen),  64'hf);
        check("r0_keep_wnum", 64'(d1_wnum), 64'd3);
        drain();

        // Backpressure honoured: no loss, no overflow.
        saw_stall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_stall(0) || m_stall(1)) idle();
            else set_wb(1'b1, 5'(1 + i % 30), $urandom, 32'h2000 + 32'(8 * i),
                        1'b1, 5'(2 + i % 29), $urandom, 32'h2004 + 32'(8 * i));
            step();
            if (d0_stall) saw_stall = 1'b1;
        end
        idle();
        check("bp_stall_seen", 64'(saw_stall), 64'd1);
        check("bp_no_ovf",     64'(d0_ovf),    64'd0);
        drain();

        // Forced overflow: fill to DEPTH ignoring stall, then one more pair.
        for (int i = 0; i < 7; i++) begin
            set_wb(1'b1, 5'd7, 32'(i), 32'h3000 + 32'(8 * i), 1'b1, 5'd8, 32'(i + 64), 32'h3004 + 32'(8 * i));
            step();
        end
        check("ovf_full_stall", 64'(d0_stall), 64'd1);
        check("ovf_before",     64'(d0_ovf),   64'd0);
        set_wb(1'b1, 5'd9, 32'h55, 32'h3100, 1'b1, 5'd10, 32'h66, 32'h3104);
        step();
        check("ovf_set", 64'(d0_ovf), 64'd1);
        idle();
        drain();
        check("ovf_sticky", 64'(d0_ovf), 64'd1);

        // Reset mid-stream with five entries queued.
        for (int i = 0; i < 4; i++) begin
            set_wb(1'b1, 5'd11, 32'(i), 32'h4000 + 32'(8 * i), 1'b1, 5'd12, 32'(i), 32'h4004 + 32'(8 * i));
            step();
        end
        idle();
        check("pre_reset_count", 64'(mq0.size()), 64'd5);
        resetn = 1'b0;
        step();
        check("rst_wen",   64'(d0_wen),   64'd0);
        check("rst_pc",    64'(d0_pc),    64'd0);
        check("rst_stall", 64'(d0_stall), 64'd0);
        check("rst_ovf",   64'(d0_ovf),   64'd0);
        resetn = 1'b1;
        set_wb(1'b1, 5'd13, 32'hFEED, 32'h5000, 1'b0, 5'd0, 32'd0, 32'd0);
        step();
        idle();
        check("post_rst_latency", 64'(d0_wen), 64'd0);
        step();
        check("post_rst_wen", 64'(d0_wen), 64'hf);
        check("post_rst_pc",  64'(d0_pc),  64'h5000);
        step();

        random_phase(150, 1'b1);
        drain();
        random_phase(150, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
